// File: rtl/platformniosci_mem_mover_pkg.sv
// Shared types and defaults for the on-chip RAM fill/copy engine.
package platformniosci_mem_mover_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_LAT = 1;
  localparam int DEF_LEN_W  = 14;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_COPY = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL_WR = 3'd1,
    CP_RD   = 3'd2,
    CP_WAIT = 3'd3,
    CP_WR   = 3'd4,
    FIN     = 3'd5
  } state_t;

endpackage

// File: rtl/platformniosci_onchip_mem_mover.sv
// Avalon-MM master that fills or copies word ranges in the single-port
// on-chip RAM. One command at a time; the RAM has fixed read latency and
// no waitrequest, so every bus cycle completes in the cycle it is driven.
// Optional feature: define MEM_MOVER_CHECKSUM_EN to add a running sum of
// all written words on the checksum output.
module platformniosci_onchip_mem_mover
  import platformniosci_mem_mover_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]   cmd_pattern,
  input  logic                cmd_abort,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata
`ifdef MEM_MOVER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]   checksum
`endif
);

  // Wait counter spans the RD_LAT cycles between read issue and capture.
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT - 1);

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   src_reg;
  logic [ADDR_W-1:0]   dst_reg;
  logic [LEN_W-1:0]    rem_reg;
  logic [DATA_W-1:0]   pattern_reg;
  logic [DATA_W-1:0]   data_reg;
  logic [WAIT_W-1:0]   wait_reg;
  logic                aborted_reg;
  logic [ADDR_W-1:0]   last_addr_reg;
  logic                accept;
  logic                abort_take;
  logic                last_word;

  assign accept     = cmd_valid && (state_reg == IDLE);
  // FIN always returns to IDLE, so abort only matters in the working states.
  assign abort_take = cmd_abort && (state_reg inside {FILL_WR, CP_RD, CP_WAIT, CP_WR});
  assign last_word  = (rem_reg == LEN_W'(1));

  assign cmd_ready    = (state_reg == IDLE);
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == FIN);
  assign aborted      = (state_reg == FIN) && aborted_reg;
  assign m_byteenable = '1;
  assign m_clken      = reset_n;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and bus outputs; the address parks on its last value when idle.
  always_comb begin
    state_next   = state_reg;
    m_chipselect = 1'b0;
    m_write      = 1'b0;
    m_address    = last_addr_reg;
    m_writedata  = '0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (cmd_len == '0) begin
            state_next = FIN;
          end else if (cmd_op == OP_COPY) begin
            state_next = CP_RD;
          end else begin
            state_next = FILL_WR;
          end
        end
      end
      FILL_WR: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_address    = dst_reg;
        m_writedata  = pattern_reg;
        if (last_word) begin
          state_next = FIN;
        end
      end
      CP_RD: begin
        m_chipselect = 1'b1;
        m_address    = src_reg;
        state_next   = CP_WAIT;
      end
      CP_WAIT: begin
        if (wait_reg == WAIT_LAST) begin
          state_next = CP_WR;
        end
      end
      CP_WR: begin
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_address    = dst_reg;
        m_writedata  = data_reg;
        state_next   = last_word ? FIN : CP_RD;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Abort wins even over a final write; the write driven this cycle still lands.
    if (abort_take) begin
      state_next = FIN;
    end
  end

  // Address/count datapath, read capture and abort flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      src_reg       <= '0;
      dst_reg       <= '0;
      rem_reg       <= '0;
      pattern_reg   <= '0;
      data_reg      <= '0;
      wait_reg      <= '0;
      aborted_reg   <= 1'b0;
      last_addr_reg <= '0;
    end else begin
      if (m_chipselect) begin
        last_addr_reg <= m_address;
      end
      if (abort_take) begin
        aborted_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            src_reg     <= cmd_src;
            dst_reg     <= cmd_dst;
            rem_reg     <= cmd_len;
            pattern_reg <= cmd_pattern;
            wait_reg    <= '0;
            aborted_reg <= 1'b0;
          end
        end
        FILL_WR, CP_WR: begin
          dst_reg <= dst_reg + ADDR_W'(1);
          rem_reg <= rem_reg - LEN_W'(1);
        end
        CP_RD: begin
          src_reg  <= src_reg + ADDR_W'(1);
          wait_reg <= '0;
        end
        CP_WAIT: begin
          wait_reg <= wait_reg + WAIT_W'(1);
          if (wait_reg == WAIT_LAST) begin
            data_reg <= m_readdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MEM_MOVER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_reg;

  assign checksum = checksum_reg;

  // Running sum of written words; cleared on accept (accept never overlaps a write).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      checksum_reg <= '0;
    end else if (accept) begin
      checksum_reg <= '0;
    end else if (m_write) begin
      checksum_reg <= checksum_reg + m_writedata;
    end
  end
`endif

endmodule

// File: tb/tb_platformniosci_onchip_mem_mover.sv
// Scoreboard bench for platformniosci_onchip_mem_mover with a RAM model.
// Build with MEM_MOVER_CHECKSUM_EN defined to also check the checksum port.
module tb_platformniosci_onchip_mem_mover;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int LW = 14;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_op;
  logic [AW-1:0] cmd_src;
  logic [AW-1:0] cmd_dst;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] cmd_pattern;
  logic          cmd_abort;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [AW-1:0] m_address;
  logic          m_chipselect;
  logic          m_write;
  logic [3:0]    m_byteenable;
  logic [DW-1:0] m_writedata;
  logic          m_clken;
  logic [DW-1:0] m_readdata;
`ifdef MEM_MOVER_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  platformniosci_onchip_mem_mover dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_src      (cmd_src),
    .cmd_dst      (cmd_dst),
    .cmd_len      (cmd_len),
    .cmd_pattern  (cmd_pattern),
    .cmd_abort    (cmd_abort),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_byteenable (m_byteenable),
    .m_writedata  (m_writedata),
    .m_clken      (m_clken),
    .m_readdata   (m_readdata)
`ifdef MEM_MOVER_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  // ---------------- RAM model (registered address, unregistered q) ----------
  logic [DW-1:0] ram [0:DEPTH-1];
  logic [AW-1:0] ram_aq = '0;
  logic          init_done = 1'b0;
  logic          poke_en = 1'b0;
  logic [AW-1:0] poke_a = '0;
  logic [DW-1:0] poke_d = '0;

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'(i) * 32'h9E3779B1 + 32'h01234567;
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
      init_done <= 1'b1;
    end else if (poke_en) begin
      ram[poke_a] <= poke_d;
    end else if (m_clken && m_chipselect && m_write) begin
      ram[m_address] <= m_writedata;
    end
    if (m_clken) ram_aq <= m_address;
  end
  assign m_readdata = ram[ram_aq];

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] old;
  } wr_t;
  typedef struct {
    bit            ab;
    int            lat;
    logic [DW-1:0] cks;
  } done_t;

  logic [DW-1:0] ref_mem [0:DEPTH-1];
  wr_t   exp_wr[$];
  done_t exp_done[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  int    n_done = 0;
  int    cs_cnt = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT writes or pulses done.
  always @(negedge clk) begin
    if (reset_n) begin
      if (m_chipselect) cs_cnt++;
      if (m_chipselect && m_write) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write_addr", 32'(m_address), 32'hFFFFFFFF);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(m_address), 32'(e.a));
          chk("wr_data", m_writedata, e.d);
          $display("WR  addr=%04h data=%08h", m_address, m_writedata);
        end
      end
      if (done) begin
        n_done++;
        if (exp_done.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          done_t d;
          d = exp_done.pop_front();
          chk("aborted", 32'(aborted), 32'(d.ab));
          chk("done_latency", 32'(cyc - acc_cyc + 1), 32'(d.lat));
          chk("writes_missing", 32'(exp_wr.size()), 32'(0));
`ifdef MEM_MOVER_CHECKSUM_EN
          chk("checksum", checksum, d.cks);
`endif
          $display("DONE aborted=%0d latency=%0d", aborted, cyc - acc_cyc + 1);
        end
      end
    end
  end

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    poke_a = a;
    poke_d = d;
    poke_en = 1'b1;
    @(posedge clk);
    #1 poke_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_flags"}, 32'({busy, done, aborted, cmd_ready, m_chipselect, m_write, m_clken}),
        32'(7'b0001000));
    chk({nm, "_be"}, 32'(m_byteenable), 32'hF);
    chk({nm, "_addr"}, 32'(m_address), 32'h0);
    chk({nm, "_wdata"}, m_writedata, 32'h0);
`ifdef MEM_MOVER_CHECKSUM_EN
    chk({nm, "_checksum"}, checksum, 32'h0);
`endif
  endtask

  // Issue one command. abort_k>0 asserts cmd_abort in cycle abort_k after
  // accept; rst_k>0 pulls reset in cycle rst_k and abandons the command;
  // hold keeps cmd_valid high while busy to exercise back-pressure.
  task automatic run_cmd(input bit op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input int len, input logic [DW-1:0] pat,
                         input int abort_k, input int rst_k, input bit hold);
    int dur;
    int nw;
    int nd0;
    int polls;
    bit ab;
    logic [DW-1:0] cks;
    logic [DW-1:0] v;
    logic [AW-1:0] a;
    logic [AW-1:0] s;
    dur = op ? 3 * len : len;
    ab  = (abort_k > 0) && (abort_k <= dur);
    nw  = !ab ? len : (op ? abort_k / 3 : abort_k);
    cks = '0;
    for (int i = 0; i < nw; i++) begin
      a = dst + AW'(i);
      s = src + AW'(i);
      v = op ? ref_mem[s] : pat;
      exp_wr.push_back('{a: a, d: v, old: ref_mem[a]});
      ref_mem[a] = v;
      cks += v;
    end
    exp_done.push_back('{ab: ab, lat: (ab ? abort_k + 1 : dur + 1), cks: cks});
    $display("CMD op=%0d src=%04h dst=%04h len=%0d pat=%08h abort_k=%0d rst_k=%0d",
             op, src, dst, len, pat, abort_k, rst_k);
    nd0 = n_done;
    cmd_op = op;
    cmd_src = src;
    cmd_dst = dst;
    cmd_len = LW'(len);
    cmd_pattern = pat;
    cmd_valid = 1'b1;
    polls = 0;
    while (!cmd_ready && polls < 50) begin
      @(posedge clk);
      #1 polls++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'(cmd_ready), 32'(1));
    @(posedge clk);
    #1 acc_cyc = cyc;
    if (!hold) cmd_valid = 1'b0;
    if (rst_k > 0) begin
      repeat (rst_k - 1) begin
        @(posedge clk);
        #1;
      end
      reset_n = 1'b0;
      @(posedge clk);
      #1 check_reset_outputs("mid_reset");
      while (exp_wr.size() > 0) begin
        wr_t e;
        e = exp_wr.pop_back();
        ref_mem[e.a] = e.old;
      end
      exp_done.delete();
      reset_n = 1'b1;
      repeat (8) begin
        @(posedge clk);
        #1;
      end
      chk("no_done_after_reset", 32'(n_done), 32'(nd0));
      return;
    end
    if (abort_k > 0) begin
      repeat (abort_k - 1) begin
        @(posedge clk);
        #1;
      end
      cmd_abort = 1'b1;
      @(posedge clk);
      #1 cmd_abort = 1'b0;
    end
    polls = 0;
    while (n_done == nd0 && polls < 100 + 4 * len) begin
      if (hold && polls == 1) chk("ready_while_busy", 32'({cmd_ready, busy}), 32'(2'b01));
      if (hold && done) cmd_valid = 1'b0;
      @(posedge clk);
      #1 polls++;
    end
    cmd_valid = 1'b0;
    if (n_done == nd0) chk("done_timeout", 32'(n_done), 32'(nd0 + 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cs0;
    int mism;
    int len;
    int dur;
    int k;
    bit op;
    logic [AW-1:0] src;
    logic [AW-1:0] dst;
    logic [DW-1:0] keep;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    reset_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 1'b0;
    cmd_src = '0;
    cmd_dst = '0;
    cmd_len = '0;
    cmd_pattern = '0;
    cmd_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // FILL 0x10..0x13 with A5A5A5A5
    run_cmd(1'b0, '0, 13'h0010, 4, 32'hA5A5A5A5, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) chk("fill_readback", ram[13'h0010 + AW'(i)], 32'hA5A5A5A5);

    // COPY RAM[0..2]=1,2,3 to 0x100; two bus cycles per word
    poke(13'h0000, 32'd1);
    poke(13'h0001, 32'd2);
    poke(13'h0002, 32'd3);
    cs0 = cs_cnt;
    run_cmd(1'b1, 13'h0000, 13'h0100, 3, '0, 0, 0, 1'b0);
    chk("copy_cs_cycles", 32'(cs_cnt - cs0), 32'd6);
    for (int i = 0; i < 3; i++) chk("copy_readback", ram[13'h0100 + AW'(i)], 32'(i + 1));

    // address wrap
    keep = ram[13'h1FFE];
    run_cmd(1'b0, '0, 13'h1FFF, 2, 32'h5EEDF00D, 0, 0, 1'b0);
    chk("wrap_top", ram[13'h1FFF], 32'h5EEDF00D);
    chk("wrap_zero", ram[13'h0000], 32'h5EEDF00D);
    chk("wrap_below_untouched", ram[13'h1FFE], keep);

    // len=0: no bus cycle
    cs0 = cs_cnt;
    run_cmd(1'b1, 13'h0040, 13'h0050, 0, '0, 0, 0, 1'b0);
    chk("len0_no_cs", 32'(cs_cnt - cs0), 32'd0);

    // back-pressure: cmd_valid held high while busy
    run_cmd(1'b0, '0, 13'h0200, 5, 32'h0BADCAFE, 0, 0, 1'b1);

    // aborts: 2nd cycle of len=8 FILL, on the final write, mid-COPY
    run_cmd(1'b0, '0, 13'h0300, 8, 32'h11223344, 2, 0, 1'b0);
    chk("abort_third_word_untouched", ram[13'h0302], ref_mem[13'h0302]);
    run_cmd(1'b0, '0, 13'h0310, 3, 32'h55667788, 3, 0, 1'b0);
    run_cmd(1'b1, 13'h0010, 13'h0320, 5, '0, 4, 0, 1'b0);

    // checksum wraps modulo 2^32
    run_cmd(1'b0, '0, 13'h0400, 3, 32'h80000000, 0, 0, 1'b0);
`ifdef MEM_MOVER_CHECKSUM_EN
    chk("checksum_wrap", checksum, 32'h80000000);
    repeat (3) @(posedge clk);
    #1 chk("checksum_stable", checksum, 32'h80000000);
`endif

    // reset in the middle of a COPY
    run_cmd(1'b1, 13'h0500, 13'h0600, 4, '0, 0, 5, 1'b0);

    // randomized commands, including overlap, wrap and aborts
    for (int n = 0; n < 40; n++) begin
      op  = 1'($urandom_range(0, 1));
      len = $urandom_range(0, 20);
      src = AW'($urandom);
      if (op && len > 0 && $urandom_range(0, 3) == 0) dst = src + AW'($urandom_range(1, len));
      else dst = AW'($urandom);
      dur = op ? 3 * len : len;
      k = (dur > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, dur) : 0;
      run_cmd(op, src, dst, len, $urandom, k, 0, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1 mism = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("memory_image_mismatches", 32'(mism), 32'd0);
    chk("scoreboard_drained", 32'(exp_wr.size() + exp_done.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
